hdmi_block_scheduler: RTL and testbench
=======================================

# hdmi_block_scheduler

Paces the decoded 8x8 block stream into `blocks_to_hdmi`, which cannot apply backpressure. It sits between the decoder output (valid/ready) and the `blocks_to_hdmi` block interface. It counts credits for the two stripe buffers and withholds `in_ready` when no buffer is free. It also generates the `blk_sof` / `blk_sob` / `blk_eob` framing markers from its own position counters.

## Interface
- `N`, 2, pixels per beat; must divide 8.
- `X_RES`, 2160, frame width in pixels; multiple of 8.
- `Y_RES`, 1200, frame height in pixels; multiple of 8.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  streaming enable; sampled only at frame boundaries.
- `stripe_done`  in  1  one-cycle pulse; the display side has freed one stripe buffer.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  upstream beat accepted when `in_valid && in_ready`.
- `in_data_y`, `in_data_cr`, `in_data_cb`  in  N×8 signed each  pixel data.
- `blk_valid`  out  1  to `blocks_to_hdmi`.
- `blk_data_y`, `blk_data_cr`, `blk_data_cb`  out  N×8 signed each  registered copy of the accepted beat.
- `blk_sob`, `blk_eob`, `blk_sof`  out  1 each  framing markers.
- `credit_err`  out  1  sticky; `stripe_done` arrived while credits were already 2.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Constants:
  - BEATS_PER_BLK = 64/N, counter `elem`.
  - BLKS_PER_STRIPE = X_RES/8, counter `blk`.
  - STRIPES = Y_RES/8, counter `stripe`.
  - Counter widths are clog2 of each count.
- Upstream order is raster over blocks; inside a block, row-major, 8/N beats per row. The scheduler never reorders data.
- Position counters advance only on an accepted beat:
  - `elem` wraps at BEATS_PER_BLK-1 and carries into `blk`.
  - `blk` wraps at BLKS_PER_STRIPE-1 and carries into `stripe`.
  - `stripe` wraps at STRIPES-1 back to 0.
- Credits (2-bit, reset value 2):
  - Decrement on the accepted last beat of a stripe (`elem` last, `blk` last).
  - Increment on `stripe_done`.
  - Both in the same cycle: value unchanged.
  - Increment at 2: saturate and set `credit_err`.
- State machine:
  - IDLE → WAIT_CREDIT when `en`=1.
  - WAIT_CREDIT → STREAM when credits > 0.
  - STREAM on the accepted last beat of a stripe:
    - last stripe of the frame and `en`=1 → WAIT_CREDIT.
    - last stripe of the frame and `en`=0 → IDLE.
    - otherwise, credits after this cycle's update > 0 → stay in STREAM.
    - otherwise → WAIT_CREDIT.
- `in_ready` = (state == STREAM). It is combinational from state only and never depends on `in_valid`.
- Deasserting `en` mid-frame has no effect until the frame completes. Frames are never truncated.
- Markers, qualified by an accepted beat:
  - `sob` = `elem`==0.
  - `eob` = `elem`==last.
  - `sof` = `elem`==0 && `blk`==0 && `stripe`==0.

## Timing
- Latency: one cycle. An input beat accepted in cycle t appears on `blk_*` in cycle t+1 with `blk_valid`=1.
- `blk_valid`=0 in every cycle that follows a non-accepted cycle. Data outputs hold their last value.
- At the first cycle after reset release:
  - `in_ready` = 0, `blk_valid` = 0, markers = 0, data = 0.
  - `credit_err` = 0, `busy` = 0, credits = 2, all position counters = 0.
- Asserting `rst_n` low mid-frame immediately returns every register to its reset value. The next frame starts with `sof` from position 0.
- Gaps (`in_valid`=0) are allowed anywhere, including inside a block. Counters hold during a gap.
- A `stripe_done` arriving in the same cycle as the final-beat decrement counts toward the STREAM-stay decision in that cycle.
- WAIT_CREDIT → STREAM takes one cycle. `in_ready` rises in the cycle after credits become nonzero.

## Structure
- Shared package `hdmi_pkg` holds:
  - `BLOCK_SIZE` = 8.
  - the `pix_t` typedef (signed [7:0]).
  - the `sched_state_t` enum {IDLE, WAIT_CREDIT, STREAM}.
- Sub-module `block_pos_counter`:
  - holds the `elem`/`blk`/`stripe` counters with the enable input.
  - outputs `is_sob`, `is_eob`, `is_sof`, `stripe_last`, `frame_last`.
  - is reusable by `blocks_to_hdmi`-style write addressing.
- Top level holds the FSM, the credit counter and the output register stage.

## Test plan
Bench parameters: N=2, X_RES=16, Y_RES=16. This gives 32 beats per block, 64 per stripe and 128 per frame.

- **Full frame:** `en`=1, `in_valid` held at 1, `stripe_done` pulses kept prompt → 128 `blk_valid` beats.
  - `sof` on beat 0 only; `sob` on beats 0/32/64/96; `eob` on beats 31/63/95/127.
  - Data out equals data in, delayed one cycle.
- **Credit stall:** no `stripe_done` pulses → exactly 128 beats accepted (2 stripes), then `in_ready`=0 and state WAIT_CREDIT. One `stripe_done` pulse → `in_ready`=1 two cycles later.
- **Simultaneous events:** `stripe_done` in the same cycle as the last beat of stripe 0, with credits=1 → credits stay 1, state stays STREAM, `in_ready` remains 1.
- **Credit overflow:** `stripe_done` while credits=2 → credits stay 2, `credit_err`=1 and stays set until reset.
- **Enable drop:** `en`=0 at beat 40 of a frame → all 128 beats still accepted, then IDLE with `busy`=0. `en`=1 again → next beat carries `sof`=1.
- **Reset mid-frame:** `rst_n` pulsed low at beat 70 → all outputs 0 and credits=2. The restart frame's first beat has `sof`=1 and `sob`=1.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI block path.
package hdmi_pkg;

   localparam int unsigned BLOCK_SIZE = 8;

   typedef logic signed [7:0] pix_t;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_CREDIT = 2'd1,
      STREAM      = 2'd2
   } sched_state_t;

   // Counter width for a count of n; never below one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/block_pos_counter.sv
// Raster position of the current beat (element / block / stripe) plus framing decodes.
module block_pos_counter
   import hdmi_pkg::*;
#(
   parameter int unsigned BEATS_PER_BLK   = 32,
   parameter int unsigned BLKS_PER_STRIPE = 270,
   parameter int unsigned STRIPES         = 150
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic is_sob,
   output logic is_eob,
   output logic is_sof,
   output logic stripe_last,
   output logic frame_last
);

   localparam int unsigned EW = cnt_w(BEATS_PER_BLK);
   localparam int unsigned BW = cnt_w(BLKS_PER_STRIPE);
   localparam int unsigned SW = cnt_w(STRIPES);
   localparam logic [EW-1:0] ELEM_LAST   = EW'(BEATS_PER_BLK - 1);
   localparam logic [BW-1:0] BLK_LAST    = BW'(BLKS_PER_STRIPE - 1);
   localparam logic [SW-1:0] STRIPE_LAST = SW'(STRIPES - 1);

   logic [EW-1:0] r_elem;
   logic [BW-1:0] r_blk;
   logic [SW-1:0] r_stripe;

   logic w_elem_last;
   logic w_blk_last;
   logic w_stripe_last;

   assign w_elem_last   = (r_elem == ELEM_LAST);
   assign w_blk_last    = (r_blk == BLK_LAST);
   assign w_stripe_last = (r_stripe == STRIPE_LAST);

   assign is_sob      = (r_elem == '0);
   assign is_eob      = w_elem_last;
   assign is_sof      = (r_elem == '0) && (r_blk == '0) && (r_stripe == '0);
   assign stripe_last = w_elem_last && w_blk_last;
   assign frame_last  = w_elem_last && w_blk_last && w_stripe_last;

   // Nested wrap: elem carries into blk, blk carries into stripe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_elem   <= '0;
         r_blk    <= '0;
         r_stripe <= '0;
      end else if (en) begin
         if (w_elem_last) begin
            r_elem <= '0;
            if (w_blk_last) begin
               r_blk    <= '0;
               r_stripe <= w_stripe_last ? '0 : r_stripe + SW'(1);
            end else begin
               r_blk <= r_blk + BW'(1);
            end
         end else begin
            r_elem <= r_elem + EW'(1);
         end
      end
   end

endmodule

// File: rtl/hdmi_block_scheduler.sv
// Credit-paced forwarding of decoded 8x8 block beats to a non-backpressuring sink, with framing markers.
module hdmi_block_scheduler
   import hdmi_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned X_RES = 2160,
   parameter int unsigned Y_RES = 1200
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  stripe_done,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [N*8-1:0] in_data_y,
   input  logic signed [N*8-1:0] in_data_cr,
   input  logic signed [N*8-1:0] in_data_cb,
   output logic                  blk_valid,
   output logic signed [N*8-1:0] blk_data_y,
   output logic signed [N*8-1:0] blk_data_cr,
   output logic signed [N*8-1:0] blk_data_cb,
   output logic                  blk_sob,
   output logic                  blk_eob,
   output logic                  blk_sof,
   output logic                  credit_err,
   output logic                  busy
);

   localparam int unsigned BEATS_PER_BLK   = (BLOCK_SIZE * BLOCK_SIZE) / N;
   localparam int unsigned BLKS_PER_STRIPE = X_RES / BLOCK_SIZE;
   localparam int unsigned STRIPES         = Y_RES / BLOCK_SIZE;
   localparam logic [1:0]  CREDITS_MAX     = 2'd2;

   sched_state_t r_state;
   sched_state_t w_state_nxt;
   logic [1:0]   r_credits;
   logic [1:0]   w_credits_nxt;
   logic         w_err_set;
   logic         w_accept;
   logic         w_stripe_end;
   logic         w_is_sob;
   logic         w_is_eob;
   logic         w_is_sof;
   logic         w_stripe_last;
   logic         w_frame_last;

   assign in_ready     = (r_state == STREAM);
   assign busy         = (r_state != IDLE);
   assign w_accept     = in_valid && in_ready;
   assign w_stripe_end = w_accept && w_stripe_last;

   block_pos_counter #(
      .BEATS_PER_BLK   (BEATS_PER_BLK),
      .BLKS_PER_STRIPE (BLKS_PER_STRIPE),
      .STRIPES         (STRIPES)
   ) u_pos (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (w_accept),
      .is_sob      (w_is_sob),
      .is_eob      (w_is_eob),
      .is_sof      (w_is_sof),
      .stripe_last (w_stripe_last),
      .frame_last  (w_frame_last)
   );

   // Credit update; a simultaneous consume and release cancel out.
   always_comb begin
      w_credits_nxt = r_credits;
      w_err_set     = 1'b0;
      if (w_stripe_end && !stripe_done) begin
         w_credits_nxt = r_credits - 2'd1;
      end else if (stripe_done && !w_stripe_end) begin
         if (r_credits >= CREDITS_MAX) begin
            w_err_set = 1'b1;
         end else begin
            w_credits_nxt = r_credits + 2'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:        if (en) w_state_nxt = WAIT_CREDIT;
         WAIT_CREDIT: if (r_credits != 2'd0) w_state_nxt = STREAM;
         STREAM: begin
            if (w_stripe_end) begin
               if (w_frame_last) begin
                  w_state_nxt = en ? WAIT_CREDIT : IDLE;
               end else if (w_credits_nxt == 2'd0) begin
                  w_state_nxt = WAIT_CREDIT;
               end
            end
         end
         default:     w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_credits  <= CREDITS_MAX;
         credit_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_credits  <= w_credits_nxt;
         credit_err <= credit_err | w_err_set;
      end
   end

   // Output stage: data holds between beats, valid and markers do not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_valid   <= 1'b0;
         blk_sob     <= 1'b0;
         blk_eob     <= 1'b0;
         blk_sof     <= 1'b0;
         blk_data_y  <= '0;
         blk_data_cr <= '0;
         blk_data_cb <= '0;
      end else begin
         blk_valid <= w_accept;
         blk_sob   <= w_accept && w_is_sob;
         blk_eob   <= w_accept && w_is_eob;
         blk_sof   <= w_accept && w_is_sof;
         if (w_accept) begin
            blk_data_y  <= in_data_y;
            blk_data_cr <= in_data_cr;
            blk_data_cb <= in_data_cb;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_block_scheduler.sv
// Scoreboard bench for hdmi_block_scheduler on a 16x16 frame (32 beats/block, 64/stripe, 128/frame).
module tb_hdmi_block_scheduler;

   localparam int unsigned N   = 2;
   localparam int unsigned W   = N * 8;
   localparam int unsigned BPB = 32;
   localparam int unsigned BPS = 64;
   localparam int unsigned BPF = 128;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  en;
   logic                  stripe_done;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [W-1:0]   in_data_y, in_data_cr, in_data_cb;
   logic                  blk_valid;
   logic signed [W-1:0]   blk_data_y, blk_data_cr, blk_data_cb;
   logic                  blk_sob, blk_eob, blk_sof;
   logic                  credit_err;
   logic                  busy;

   typedef struct {
      logic [W-1:0] y;
      logic [W-1:0] cr;
      logic [W-1:0] cb;
      logic         sob;
      logic         eob;
      logic         sof;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   pos     = 0;
   int   acc     = 0;
   bit   sd_prompt  = 1'b0;
   bit   sd_at_end  = 1'b0;
   bit   sd_force   = 1'b0;
   bit   prev_se    = 1'b0;

   always #5 clk = ~clk;

   hdmi_block_scheduler #(.N(N), .X_RES(16), .Y_RES(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .stripe_done (stripe_done),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data_y   (in_data_y),
      .in_data_cr  (in_data_cr),
      .in_data_cb  (in_data_cb),
      .blk_valid   (blk_valid),
      .blk_data_y  (blk_data_y),
      .blk_data_cr (blk_data_cr),
      .blk_data_cb (blk_data_cb),
      .blk_sob     (blk_sob),
      .blk_eob     (blk_eob),
      .blk_sof     (blk_sof),
      .credit_err  (credit_err),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every output beat must match the oldest expected beat.
   always @(negedge clk) begin
      if (rst_n && blk_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat: got unexpected output beat, expected none at %0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("beat", {blk_data_y, blk_data_cr, blk_data_cb, blk_sob, blk_eob, blk_sof},
                {e.y, e.cr, e.cb, e.sob, e.eob, e.sof});
         end
      end
   end

   // One clock of stimulus; pushes the expected output when the beat will be accepted.
   task automatic cycle(input bit v);
      exp_t e;
      @(negedge clk);
      in_valid    = v;
      in_data_y   = W'($urandom);
      in_data_cr  = W'($urandom);
      in_data_cb  = W'($urandom);
      stripe_done = sd_force || (sd_prompt && prev_se);
      prev_se     = 1'b0;
      if (v && in_ready) begin
         if (sd_at_end && (pos % BPS == BPS - 1)) stripe_done = 1'b1;
         e.y   = in_data_y;
         e.cr  = in_data_cr;
         e.cb  = in_data_cb;
         e.sob = (pos % BPB == 0);
         e.eob = (pos % BPB == BPB - 1);
         e.sof = (pos == 0);
         q.push_back(e);
         prev_se = (pos % BPS == BPS - 1);
         pos     = (pos + 1) % BPF;
         acc++;
      end
   endtask

   task automatic run_until(input string name, input int target, input int budget, input bit gaps);
      int k = 0;
      while (acc < target && k < budget) begin
         cycle(gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
         k++;
      end
      chk(name, acc, target);
   endtask

   task automatic run_for(input int n, input bit v);
      for (int i = 0; i < n; i++) cycle(v);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_n       = 1'b0;
      en          = 1'b0;
      in_valid    = 1'b0;
      stripe_done = 1'b0;
      sd_prompt   = 1'b0;
      sd_at_end   = 1'b0;
      sd_force    = 1'b0;
      prev_se     = 1'b0;
      pos         = 0;
      q.delete();
      @(negedge clk);
      chk({name, "_rst_out"},
          {in_ready, blk_valid, blk_sob, blk_eob, blk_sof, credit_err, busy,
           blk_data_y, blk_data_cr, blk_data_cb}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk({name, "_post_rst"}, {in_ready, blk_valid, blk_sof, credit_err, busy}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      rst_n = 1'b0; en = 1'b0; stripe_done = 1'b0; in_valid = 1'b0;
      in_data_y = '0; in_data_cr = '0; in_data_cb = '0;

      // Full frame with prompt stripe releases.
      do_reset("t1");
      en = 1'b1;
      cycle(0);
      chk("t1_wait_ready", {in_ready, busy}, 64'b01);
      cycle(0);
      chk("t1_stream_ready", in_ready, 1'b1);
      sd_prompt = 1'b1;
      acc0 = acc;
      run_until("t1_frame", acc0 + BPF, 300, 1'b0);
      en = 1'b0;
      run_for(3, 1'b0);
      chk("t1_idle_valid", blk_valid, 1'b0);

      // Credit stall, then single release and same-cycle release at stripe end.
      do_reset("t2");
      en = 1'b1;
      acc0 = acc;
      run_for(300, 1'b1);
      chk("t2_stall_beats", acc - acc0, BPF);
      chk("t2_stall_state", {in_ready, busy}, 64'b01);
      sd_force = 1'b1;
      cycle(0);
      sd_force = 1'b0;
      cycle(0);
      chk("t2_ready_1cyc", in_ready, 1'b0);
      cycle(0);
      chk("t2_ready_2cyc", in_ready, 1'b1);
      acc0 = acc;
      sd_at_end = 1'b1;
      run_until("t3_stripe0", acc0 + BPS, 200, 1'b0);
      sd_at_end = 1'b0;
      cycle(0);
      chk("t3_stay_stream", in_ready, 1'b1);
      run_until("t3_stripe1", acc0 + BPF, 200, 1'b0);
      run_for(4, 1'b1);
      chk("t3_credits_out", {in_ready, busy}, 64'b01);
      chk("t3_no_extra", acc - acc0, BPF);

      // Release while already full.
      do_reset("t4");
      sd_force = 1'b1;
      cycle(0);
      sd_force = 1'b0;
      cycle(0);
      chk("t4_err_set", credit_err, 1'b1);
      en = 1'b1;
      acc0 = acc;
      run_for(300, 1'b1);
      chk("t4_saturated", acc - acc0, BPF);
      chk("t4_err_sticky", credit_err, 1'b1);

      // Enable dropped mid-frame, with random gaps.
      do_reset("t5");
      en = 1'b1;
      sd_prompt = 1'b1;
      acc0 = acc;
      run_until("t5_beat40", acc0 + 40, 400, 1'b1);
      en = 1'b0;
      run_until("t5_frame", acc0 + BPF, 800, 1'b1);
      run_for(3, 1'b1);
      chk("t5_idle", {in_ready, busy}, 64'b00);
      chk("t5_no_extra", acc - acc0, BPF);
      en = 1'b1;
      run_until("t5_restart", acc0 + BPF + 4, 50, 1'b0);
      run_for(2, 1'b0);

      // Reset mid-frame at beat 70.
      do_reset("t6");
      en = 1'b1;
      sd_prompt = 1'b1;
      acc0 = acc;
      run_until("t6_beat70", acc0 + 70, 200, 1'b0);
      run_for(2, 1'b0);
      do_reset("t6b");
      en = 1'b1;
      acc0 = acc;
      run_for(300, 1'b1);
      chk("t6_full_credits", acc - acc0, BPF);
      run_for(2, 1'b0);

      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
